// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter width, lookup stage codes, sequencer states,
// default notch positions and small position helpers.
package enigma_pkg;

   localparam int LW = 6;

   localparam logic [LW-1:0] NUM_LETTERS = 6'd26;
   localparam logic [LW-1:0] LAST_LETTER = 6'd25;

   localparam logic [2:0] LK_FWD0 = 3'd0;
   localparam logic [2:0] LK_FWD1 = 3'd1;
   localparam logic [2:0] LK_FWD2 = 3'd2;
   localparam logic [2:0] LK_REFL = 3'd3;
   localparam logic [2:0] LK_REV0 = 3'd4;
   localparam logic [2:0] LK_REV1 = 3'd5;
   localparam logic [2:0] LK_REV2 = 3'd6;

   localparam logic [LW-1:0] NOTCH0_DEF = 6'd16;
   localparam logic [LW-1:0] NOTCH1_DEF = 6'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_STEP,
      ST_FWD0,
      ST_FWD1,
      ST_FWD2,
      ST_REFL,
      ST_REV2,
      ST_REV1,
      ST_REV0,
      ST_HOLD
   } state_e;

   function automatic logic [LW-1:0] pos_inc(input logic [LW-1:0] p);
      return (p >= LAST_LETTER) ? '0 : p + 6'd1;
   endfunction

   function automatic logic [LW-1:0] pos_clamp(input logic [LW-1:0] p);
      return (p < NUM_LETTERS) ? p : '0;
   endfunction

endpackage

// File: rtl/enigma_rotor_stepper.sv
// enigma_rotor_stepper: combinational next rotor positions from current ones.
// Define ENIGMA_DOUBLE_STEP_EN for the historical double-step of rotor1.
module enigma_rotor_stepper
   import enigma_pkg::*;
#(
   parameter logic [LW-1:0] NOTCH0 = NOTCH0_DEF,
   parameter logic [LW-1:0] NOTCH1 = NOTCH1_DEF
) (
   input  logic [LW-1:0] pos0_i,
   input  logic [LW-1:0] pos1_i,
   input  logic [LW-1:0] pos2_i,
   output logic [LW-1:0] pos0_o,
   output logic [LW-1:0] pos1_o,
   output logic [LW-1:0] pos2_o
);

   logic carry0;
   logic at_notch1;

   always_comb begin
      carry0    = (pos0_i == NOTCH0);
      at_notch1 = (pos1_i == NOTCH1);
      pos0_o    = pos_inc(pos0_i);
      pos1_o    = pos1_i;
      pos2_o    = pos2_i;
`ifdef ENIGMA_DOUBLE_STEP_EN
      // rotor1 sitting on its notch advances itself and rotor2 regardless of rotor0
      if (carry0 || at_notch1) pos1_o = pos_inc(pos1_i);
      if (at_notch1)           pos2_o = pos_inc(pos2_i);
`else
      if (carry0) begin
         pos1_o = pos_inc(pos1_i);
         if (at_notch1) pos2_o = pos_inc(pos2_i);
      end
`endif
   end

endmodule

// File: rtl/enigma_rotor_sequencer.sv
// enigma_rotor_sequencer: steps rotors then walks one letter through the shared
// lookup datapath, fwd0..reflector..rev0. Stepping mode: ENIGMA_DOUBLE_STEP_EN.
module enigma_rotor_sequencer
   import enigma_pkg::*;
#(
   parameter logic [LW-1:0] NOTCH0 = NOTCH0_DEF,
   parameter logic [LW-1:0] NOTCH1 = NOTCH1_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [LW-1:0] in_letter,
   input  logic          cfg_load,
   input  logic [LW-1:0] cfg_pos0,
   input  logic [LW-1:0] cfg_pos1,
   input  logic [LW-1:0] cfg_pos2,
   output logic          cfg_busy,
   output logic [2:0]    lk_sel,
   output logic [LW-1:0] lk_data,
   output logic [LW-1:0] lk_pos,
   input  logic [LW-1:0] lk_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [LW-1:0] out_letter,
   output logic [LW-1:0] pos0,
   output logic [LW-1:0] pos1,
   output logic [LW-1:0] pos2
);

   state_e        state_q, state_d;
   logic [LW-1:0] letter_q, letter_d;
   logic [LW-1:0] pos0_q, pos0_d;
   logic [LW-1:0] pos1_q, pos1_d;
   logic [LW-1:0] pos2_q, pos2_d;
   logic [LW-1:0] step0, step1, step2;

   enigma_rotor_stepper #(
      .NOTCH0(NOTCH0),
      .NOTCH1(NOTCH1)
   ) u_stepper (
      .pos0_i(pos0_q),
      .pos1_i(pos1_q),
      .pos2_i(pos2_q),
      .pos0_o(step0),
      .pos1_o(step1),
      .pos2_o(step2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         letter_q <= '0;
         pos0_q   <= '0;
         pos1_q   <= '0;
         pos2_q   <= '0;
      end else begin
         state_q  <= state_d;
         letter_q <= letter_d;
         pos0_q   <= pos0_d;
         pos1_q   <= pos1_d;
         pos2_q   <= pos2_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      letter_d   = letter_q;
      pos0_d     = pos0_q;
      pos1_d     = pos1_q;
      pos2_d     = pos2_q;
      in_ready   = 1'b0;
      cfg_busy   = 1'b1;
      out_valid  = 1'b0;
      out_letter = '0;
      lk_sel     = LK_FWD0;
      lk_data    = '0;
      lk_pos     = '0;
      unique case (state_q)
         ST_IDLE: begin
            cfg_busy = 1'b0;
            // a config pulse takes priority and refuses the letter this cycle
            in_ready = !cfg_load;
            if (cfg_load) begin
               pos0_d = pos_clamp(cfg_pos0);
               pos1_d = pos_clamp(cfg_pos1);
               pos2_d = pos_clamp(cfg_pos2);
            end else if (in_valid) begin
               letter_d = in_letter;
               state_d  = (in_letter < NUM_LETTERS) ? ST_STEP : ST_HOLD;
            end
         end
         ST_STEP: begin
            pos0_d  = step0;
            pos1_d  = step1;
            pos2_d  = step2;
            state_d = ST_FWD0;
         end
         ST_FWD0: begin
            lk_sel   = LK_FWD0;
            lk_data  = letter_q;
            lk_pos   = pos0_q;
            letter_d = lk_result;
            state_d  = ST_FWD1;
         end
         ST_FWD1: begin
            lk_sel   = LK_FWD1;
            lk_data  = letter_q;
            lk_pos   = pos1_q;
            letter_d = lk_result;
            state_d  = ST_FWD2;
         end
         ST_FWD2: begin
            lk_sel   = LK_FWD2;
            lk_data  = letter_q;
            lk_pos   = pos2_q;
            letter_d = lk_result;
            state_d  = ST_REFL;
         end
         ST_REFL: begin
            lk_sel   = LK_REFL;
            lk_data  = letter_q;
            letter_d = lk_result;
            state_d  = ST_REV2;
         end
         ST_REV2: begin
            lk_sel   = LK_REV2;
            lk_data  = letter_q;
            lk_pos   = pos2_q;
            letter_d = lk_result;
            state_d  = ST_REV1;
         end
         ST_REV1: begin
            lk_sel   = LK_REV1;
            lk_data  = letter_q;
            lk_pos   = pos1_q;
            letter_d = lk_result;
            state_d  = ST_REV0;
         end
         ST_REV0: begin
            lk_sel   = LK_REV0;
            lk_data  = letter_q;
            lk_pos   = pos0_q;
            letter_d = lk_result;
            state_d  = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid  = 1'b1;
            out_letter = letter_q;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pos0 = pos0_q;
   assign pos1 = pos1_q;
   assign pos2 = pos2_q;

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
// Self-checking bench for enigma_rotor_sequencer: directed vector table, random
// letters against an arithmetic Enigma model, and hand-written corner sequences.
module tb_enigma_rotor_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [5:0] in_letter = '0;
   logic       cfg_load = 1'b0;
   logic [5:0] cfg_pos0 = '0, cfg_pos1 = '0, cfg_pos2 = '0;
   logic       cfg_busy;
   logic [2:0] lk_sel;
   logic [5:0] lk_data, lk_pos, lk_result;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [5:0] out_letter;
   logic [5:0] pos0, pos1, pos2;

   enigma_rotor_sequencer #(.NOTCH0(6'd16), .NOTCH1(6'd4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
      .cfg_load(cfg_load), .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2),
      .cfg_busy(cfg_busy),
      .lk_sel(lk_sel), .lk_data(lk_data), .lk_pos(lk_pos), .lk_result(lk_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter),
      .pos0(pos0), .pos1(pos1), .pos2(pos2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int m0 = 0, m1 = 0, m2 = 0;
   bit ident = 1'b1;
   int MUL[3]  = '{3, 5, 7};
   int MINV[3] = '{9, 21, 15};
   int ADD[3]  = '{1, 10, 19};

   // rotor wiring as affine maps mod 26, shifted by rotor position
   function automatic int fwd(input int i, input int x, input int q);
      int v = (x + q) % 26;
      v = (v * MUL[i] + ADD[i]) % 26;
      return (v - q + 26) % 26;
   endfunction

   function automatic int rev(input int i, input int x, input int q);
      int v = (x + q) % 26;
      v = ((v - ADD[i] + 26) * MINV[i]) % 26;
      return (v - q + 26) % 26;
   endfunction

   function automatic logic [5:0] lookup(input logic [2:0] sel, input logic [5:0] d, input logic [5:0] p);
      int x = (d > 6'd25) ? 0 : int'(d);
      int q = (p > 6'd25) ? 0 : int'(p);
      int r;
      case (sel)
         3'd0, 3'd1, 3'd2: r = fwd(int'(sel), x, q);
         3'd3:             r = x ^ 1;
         3'd4, 3'd5, 3'd6: r = rev(int'(sel) - 4, x, q);
         default:          r = 0;
      endcase
      return 6'(r);
   endfunction

   always_comb lk_result = ident ? lk_data : lookup(lk_sel, lk_data, lk_pos);

   function automatic int encrypt(input int x);
      int y = x;
      y = fwd(0, y, m0);
      y = fwd(1, y, m1);
      y = fwd(2, y, m2);
      y = y ^ 1;
      y = rev(2, y, m2);
      y = rev(1, y, m1);
      y = rev(0, y, m0);
      return y;
   endfunction

   function automatic void model_step();
      bit c1 = (m0 == 16);
      bit n1 = (m1 == 4);
      m0 = (m0 + 1) % 26;
`ifdef ENIGMA_DOUBLE_STEP_EN
      if (n1) begin
         m1 = (m1 + 1) % 26;
         m2 = (m2 + 1) % 26;
      end else if (c1) begin
         m1 = (m1 + 1) % 26;
      end
`else
      if (c1) begin
         if (n1) m2 = (m2 + 1) % 26;
         m1 = (m1 + 1) % 26;
      end
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_cfg(input int a, input int b, input int c);
      cfg_load = 1'b1;
      cfg_pos0 = 6'(a);
      cfg_pos1 = 6'(b);
      cfg_pos2 = 6'(c);
      @(posedge clk); #1;
      cfg_load = 1'b0;
      m0 = (a > 25) ? 0 : a;
      m1 = (b > 25) ? 0 : b;
      m2 = (c > 25) ? 0 : c;
   endtask

   task automatic offer(input int l);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("offer_ready", 0, 1);
      in_valid  = 1'b1;
      in_letter = 6'(l);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (l < 26) model_step();
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out(input int delay);
      for (int k = 0; k < delay; k++) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_ov", int'(out_valid), 0);
   endtask

   task automatic chk_pos(input string tag, input int e0, input int e1, input int e2);
      chk({tag, "_pos0"}, int'(pos0), e0);
      chk({tag, "_pos1"}, int'(pos1), e1);
      chk({tag, "_pos2"}, int'(pos2), e2);
   endtask

   typedef struct {
      bit do_cfg;
      int c0, c1, c2;
      int letter;
      int e_out, e0, e1, e2, e_lat;
   } vec_t;

   vec_t vt[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int exp_out;
      int seen;

      vt[0] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 8};
      vt[1] = '{1, 16, 0, 0, 5, 5, 17, 1, 0, 8};
      vt[2] = '{1, 25, 25, 25, 7, 7, 0, 25, 25, 8};
      vt[3] = '{1, 16, 3, 0, 2, 2, 17, 4, 0, 8};
`ifdef ENIGMA_DOUBLE_STEP_EN
      vt[4] = '{0, 0, 0, 0, 3, 3, 18, 5, 1, 8};
`else
      vt[4] = '{0, 0, 0, 0, 3, 3, 18, 4, 0, 8};
`endif
      vt[5] = '{1, 40, 30, 63, 1, 1, 1, 0, 0, 8};
      vt[6] = '{0, 0, 0, 0, 30, 30, 1, 0, 0, 0};
`ifdef ENIGMA_DOUBLE_STEP_EN
      vt[7] = '{1, 15, 4, 9, 10, 10, 16, 5, 10, 8};
      vt[8] = '{0, 0, 0, 0, 11, 11, 17, 6, 10, 8};
`else
      vt[7] = '{1, 15, 4, 9, 10, 10, 16, 4, 9, 8};
      vt[8] = '{0, 0, 0, 0, 11, 11, 17, 5, 10, 8};
`endif
      vt[9] = '{1, 16, 25, 3, 12, 12, 17, 0, 3, 8};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_letter", int'(out_letter), 0);
      chk("rst_cfg_busy", int'(cfg_busy), 0);
      chk("rst_lk_sel", int'(lk_sel), 0);
      chk("rst_lk_data", int'(lk_data), 0);
      chk("rst_lk_pos", int'(lk_pos), 0);
      chk_pos("rst", 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vectors with identity lookup
      ident = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (vt[i].do_cfg) load_cfg(vt[i].c0, vt[i].c1, vt[i].c2);
         offer(vt[i].letter);
         wait_out(lat);
         chk($sformatf("vec%0d_lat", i), lat, vt[i].e_lat);
         chk($sformatf("vec%0d_out", i), int'(out_letter), vt[i].e_out);
         chk_pos($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].e2);
         release_out(0);
         chk($sformatf("vec%0d_idle", i), int'(in_ready), 1);
      end

      // random letters through the non-trivial lookup model
      ident = 1'b0;
      for (int i = 0; i < 30; i++) begin
         int l;
         if ($urandom_range(0, 3) == 0)
            load_cfg(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(26, 40)) : int'($urandom_range(0, 25));
         offer(l);
         exp_out = (l < 26) ? encrypt(l) : l;
         wait_out(lat);
         chk($sformatf("rnd%0d_lat", i), lat, (l < 26) ? 8 : 0);
         chk($sformatf("rnd%0d_out", i), int'(out_letter), exp_out);
         chk_pos($sformatf("rnd%0d", i), m0, m1, m2);
         release_out(int'($urandom_range(0, 3)));
      end

      // output stall: held output, busy config, ignored cfg_load and in_valid
      load_cfg(5, 6, 7);
      offer(9);
      exp_out = encrypt(9);
      wait_out(lat);
      chk("stall_lat", lat, 8);
      for (int k = 0; k < 20; k++) begin
         if (k == 5) begin
            cfg_load = 1'b1;
            cfg_pos0 = 6'd1; cfg_pos1 = 6'd2; cfg_pos2 = 6'd3;
            in_valid = 1'b1; in_letter = 6'd0;
         end
         @(posedge clk); #1;
         cfg_load = 1'b0;
         in_valid = 1'b0;
         chk($sformatf("stall%0d_ov", k), int'(out_valid), 1);
         chk($sformatf("stall%0d_out", k), int'(out_letter), exp_out);
         chk($sformatf("stall%0d_rdy", k), int'(in_ready), 0);
         chk($sformatf("stall%0d_busy", k), int'(cfg_busy), 1);
      end
      chk_pos("stall", m0, m1, m2);
      release_out(0);
      chk("stall_idle", int'(in_ready), 1);

      // cfg_load and in_valid together: config wins, letter refused
      cfg_load = 1'b1;
      cfg_pos0 = 6'd20; cfg_pos1 = 6'd21; cfg_pos2 = 6'd22;
      in_valid = 1'b1; in_letter = 6'd4;
      #1;
      chk("both_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
      m0 = 20; m1 = 21; m2 = 22;
      chk_pos("both", 20, 21, 22);
      chk("both_busy", int'(cfg_busy), 0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      chk("both_no_out", seen, 0);

      // reset during FWD1
      offer(3);
      lat = 0;
      while (lk_sel != 3'd1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rst_mid_fwd1_seen", int'(lk_sel), 1);
      rst_n = 1'b0;
      #1;
      chk_pos("rst_mid", 0, 0, 0);
      chk("rst_mid_ov", int'(out_valid), 0);
      chk("rst_mid_rdy", int'(in_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m0 = 0; m1 = 0; m2 = 0;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      chk("rst_mid_no_out", seen, 0);
      chk_pos("rst_mid_after", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
